// File: rtl/rr_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// requester count, select width and the select-to-one-hot helper.
package rr_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    onehot4 = NUM_REQ'(1) << sel;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first candidate after last_grant,
// wrapping 3->0, with last_grant itself checked last.
module rr_priority_pick
  import rr_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [SEL_W-1:0]   last_grant,
  output logic [SEL_W-1:0]   grant,
  output logic               any_cand
);

  logic [SEL_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant    = '0;
    any_cand = 1'b0;
    idx      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = last_grant + SEL_W'(i);
      if (cand[idx]) begin
        grant    = idx;
        any_cand = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin scheduler for four FWFT VC FIFOs feeding the shared registered
// output mux; owns the mux select and the downstream push.
module rr_arbiter4
  import rr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] fifo_empty,
  input  logic               out_almost_full,
  output logic [NUM_REQ-1:0] pop,
  output logic [SEL_W-1:0]   select,
  output logic               push,
  output logic               busy
);

  state_t              state;
  logic [SEL_W-1:0]    last_grant;
  logic [NUM_REQ-1:0]  cand;
  logic [SEL_W-1:0]    grant;
  logic                any_cand;

  // A FIFO popped this cycle still shows its old empty flag, so mask it out.
  assign cand = ~fifo_empty & ~pop;

  rr_priority_pick u_pick (
    .cand       (cand),
    .last_grant (last_grant),
    .grant      (grant),
    .any_cand   (any_cand)
  );

  assign busy = (state == SERVE);

  // IDLE, SERVE and HOLD share one set of exit rules; the state only records
  // why no pop (or which kind of pop) is in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (!reset) begin
      state      <= IDLE;
      pop        <= '0;
      select     <= '0;
      push       <= 1'b0;
      last_grant <= SEL_W'(NUM_REQ - 1);
    end else begin
      // The mux registers the selected word this edge, so push lines up with it.
      push <= |pop;
      if (out_almost_full) begin
        state <= HOLD;
        pop   <= '0;
      end else if (any_cand) begin
        state      <= SERVE;
        pop        <= onehot4(grant);
        select     <= grant;
        last_grant <= grant;
      end else begin
        state <= IDLE;
        pop   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: word-count model of the four VC FIFOs,
// hand-computed pop/select/push/busy tables per scenario.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] fifo_empty = 4'hf;
  logic       out_almost_full = 1'b0;
  logic [3:0] pop;
  logic [1:0] select;
  logic       push;
  logic       busy;

  int cnt [4];
  int total = 0;
  int bad = 0;

  rr_arbiter4 dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_empty      (fifo_empty),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .select          (select),
    .push            (push),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_empty();
    for (int i = 0; i < 4; i++) fifo_empty[i] = (cnt[i] == 0);
  endtask

  // Retire one word from each popped FIFO; only the DUT's next edge sees it.
  task automatic fifo_update();
    for (int i = 0; i < 4; i++)
      if (pop[i] && cnt[i] > 0) cnt[i] = cnt[i] - 1;
    set_empty();
  endtask

  task automatic do_reset(input int c0, input int c1, input int c2, input int c3);
    reset = 1'b0;
    out_almost_full = 1'b0;
    repeat (2) @(negedge clk);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    set_empty();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cnt[0] = 3; cnt[1] = 3; cnt[2] = 3; cnt[3] = 3;
    set_empty();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({pop, select, push, busy} !== 8'b0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: pop=%b select=%0d push=%b busy=%b, required all zero",
                 i, pop, select, push, busy);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (pop !== 4'b0001 || select !== 2'd0 || push !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_grant: pop=%b select=%0d push=%b busy=%b, required 0001/0/0/1",
               pop, select, push, busy);
    end
    fifo_update();
    @(negedge clk);
    total++;
    if (pop !== 4'b0010 || push !== 1'b1) begin
      bad++;
      $display("FAIL reset_second_grant: pop=%b push=%b, required 0010/1", pop, push);
    end
  endtask

  task automatic test_all_busy();
    logic [3:0] ep;
    logic [1:0] es;
    logic       eu;
    int         pushes = 0;
    do_reset(3, 3, 3, 3);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ep = (i < 12) ? (4'b0001 << (i % 4)) : 4'b0000;
      es = (i < 12) ? 2'(i % 4) : 2'd3;
      eu = (i >= 1 && i <= 12);
      if (push) pushes++;
      total++;
      if (pop !== ep || select !== es || push !== eu || busy !== (i < 12)) begin
        bad++;
        $display("FAIL all_busy cycle %0d: pop=%b select=%0d push=%b busy=%b, required %b/%0d/%b/%b",
                 i, pop, select, push, busy, ep, es, eu, (i < 12));
      end
      fifo_update();
    end
    total++;
    if (pushes != 12) begin
      bad++;
      $display("FAIL all_busy_push_count: got %0d pushes, required 12", pushes);
    end
  endtask

  task automatic test_single();
    logic [3:0] ep [5] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic       eu [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset(0, 0, 2, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (pop !== ep[i] || push !== eu[i] || select !== 2'd2) begin
        bad++;
        $display("FAIL single_fifo cycle %0d: pop=%b push=%b select=%0d, required %b/%b/2",
                 i, pop, push, select, ep[i], eu[i]);
      end
      fifo_update();
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ep [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    logic [1:0] es [6] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3};
    logic       eu [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset(0, 2, 0, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (pop !== ep[i] || select !== es[i] || push !== eu[i]) begin
        bad++;
        $display("FAIL wrap cycle %0d: pop=%b select=%0d push=%b, required %b/%0d/%b",
                 i, pop, select, push, ep[i], es[i], eu[i]);
      end
      fifo_update();
    end
  endtask

  task automatic test_almost_full();
    logic [3:0] ep [9] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                           4'b0001, 4'b0010, 4'b0000, 4'b0000};
    logic [1:0] es [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
    logic       eu [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eb [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       af [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset(2, 2, 0, 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total++;
      if (pop !== ep[i] || select !== es[i] || push !== eu[i] || busy !== eb[i]) begin
        bad++;
        $display("FAIL almost_full cycle %0d: pop=%b select=%0d push=%b busy=%b, required %b/%0d/%b/%b",
                 i, pop, select, push, busy, ep[i], es[i], eu[i], eb[i]);
      end
      fifo_update();
      out_almost_full = af[i];
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2, 2, 2, 2);
    @(negedge clk);
    fifo_update();
    @(negedge clk);
    total++;
    if (pop !== 4'b0010 || select !== 2'd1) begin
      bad++;
      $display("FAIL reset_mid_setup: pop=%b select=%0d, required 0010/1", pop, select);
    end
    fifo_update();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (pop !== 4'b0000 || push !== 1'b0 || busy !== 1'b0 || select !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_clear: pop=%b push=%b busy=%b select=%0d, required 0000/0/0/0",
               pop, push, busy, select);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (pop !== 4'b0001 || select !== 2'd0 || push !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_restart: pop=%b select=%0d push=%b, required 0001/0/0",
               pop, select, push);
    end
  endtask

  initial begin
    test_reset();
    test_all_busy();
    test_single();
    test_wrap();
    test_almost_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin scheduler sharing the 4:1 registered 10-bit output mux (mux4x1) between four first-word-fall-through (FWFT) virtual-channel FIFOs.
- Each cycle, picks at most one non-empty FIFO. Drives that FIFO's pop and the mux select, then pushes the mux output into the downstream FIFO one cycle later.
- Sits between the VC FIFOs and the output FIFO in the complete module; it is the only source of the mux select.

Parameters:
- NUM_REQ, 4, number of requesters. Fixed; other values unsupported.
- SEL_W, 2, width of select and grant pointer.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low
- fifo_empty  input  4  empty flag of VC FIFO i (bit i)
- out_almost_full  input  1  downstream FIFO almost full; threshold leaves at least 2 free slots
- pop  output  4  one-hot pop to VC FIFO i, registered
- select  output  2  mux select, registered, equals index of the asserted pop bit
- push  output  1  downstream push, registered, aligned with valid out_mux
- busy  output  1  high while state is SERVE

Behaviour:
- Reset (reset==0 at a rising edge):
  - pop=0, select=0, push=0, busy=0, state=IDLE, last_grant=3.
  - Any in-flight push is dropped.
  - The top level drives the mux's reset with the inverted reset, so mux and arbiter clear on the same edge.
- Candidate set, evaluated every cycle:
  - cand[i] = ~fifo_empty[i] & ~pop[i].
  - A FIFO popped in the current cycle is excluded, because its empty flag does not yet reflect that pop.
  - Consequence: a lone requester is served at most every other cycle.
- Grant: the first i with cand[i]=1, searching last_grant+1, +2, +3, +4 modulo 4 (wrap 3->0).
- States: IDLE, SERVE, HOLD.
  - IDLE: pop=0. Next state:
    - HOLD if out_almost_full=1.
    - else SERVE if any cand (register pop=onehot(g), select=g, last_grant=g).
    - else stay IDLE.
  - SERVE: pop is asserted this cycle. Next state:
    - HOLD if out_almost_full=1 (pop cleared).
    - else SERVE with a new grant if any cand.
    - else IDLE (pop cleared).
  - HOLD: pop=0. Leave to SERVE or IDLE using the IDLE rules once out_almost_full=0.
- select holds its last value whenever pop=0; it is never changed without a matching pop.
- Data path timing:
  - Pop of FIFO g asserted in cycle k with select=g.
  - The mux samples in_g at the end of cycle k, so out_mux is valid in cycle k+1.
  - push = registered |pop, so push=1 exactly in cycle k+1.
  - Latency from pop to push is 1 cycle.
- out_almost_full rising in the same cycle as a pop: that pop completes and its push still occurs (relies on the 2-slot margin). No further pop is issued.
- fifo_empty[g] rising in the cycle after g was granted has no effect; that FIFO is already excluded from cand.
- At most one pop bit is ever high. No pop is ever issued to an empty FIFO.
- Reset asserted mid-SERVE: pop and push are 0 on the following cycle, and the pointer restarts with FIFO 0 first.

Decomposition:
- Shared package, rr_pkg:
  - state encoding: IDLE=2'd0, SERVE=2'd1, HOLD=2'd2
  - NUM_REQ and SEL_W constants
  - function onehot4(sel)
- One sub-module is natural: rr_priority_pick. It is combinational: inputs cand[3:0] and last_grant[1:0], outputs grant[1:0] and any_cand.
- The FSM, pointer and output registers live in rr_arbiter4.

Test Plan:
- Reset held low for 3 cycles, all FIFOs non-empty -> pop=0, select=0, push=0 throughout. First grant after release goes to FIFO 0.
- FIFOs 0-3 all holding 3 words, out_almost_full=0 -> pop sequence 0,1,2,3,0,1,2,3,... on consecutive cycles. push follows each pop by 1 cycle. 12 pushes total, then IDLE.
- Only FIFO 2 non-empty with 2 words -> pop[2] in cycles k and k+2, none in k+1. push in k+1 and k+3. select stays 2.
- FIFOs 1 and 3 non-empty, last_grant=1 -> next grant is 3, then 1 (wrap-around). FIFOs 0 and 2 are never popped.
- out_almost_full rises in the same cycle as pop[0] -> push occurs the next cycle. No pop while out_almost_full=1. Service resumes with FIFO 1 the cycle after it falls.
- Reset asserted in a cycle with pop[1]=1 -> the next cycle has pop=0, push=0, state IDLE. After release, the first grant is FIFO 0.
